vending_ctrl: RTL and testbench

Transaction controller for the vending machine. Accumulates coin credit, arbitrates a 2-product selection against that credit, and sequences the shared dispense motor through a req/done handshake. Returns surplus credit as a train of 5-unit change pulses. Sits between the coin acceptor / keypad front end and the motor and change-hopper drivers.

---
 rtl/vend_pkg.sv | 25 ++
 rtl/vend_timer.sv | 31 +++
 rtl/vending_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vending_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared encodings for the vending controller.
// Coin/selection codes, FSM state enum and coin values.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_A      = 2'b01;
  localparam logic [1:0] SEL_B      = 2'b10;
  localparam logic [1:0] SEL_CANCEL = 2'b11;

  localparam int VAL_5  = 5;
  localparam int VAL_10 = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VEND,
    S_CHANGE,
    S_FAULT
  } state_e;

endpackage

// File: rtl/vend_timer.sv
// Clearable up-counter with terminal-count flag (dispense watchdog).
// Ports: clk, rst (sync active-low), clr_i, tc_o (count == TC-1).
module vend_timer #(
  parameter int TC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tc_o
);

  localparam int W = $clog2(TC + 1);
  localparam logic [W-1:0] LAST = W'(TC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (!tc_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vending_ctrl.sv
// Vending transaction controller: credit, selection, motor handshake, change.
// Ports: clk, rst(n), coin, sel, motor_done in; motor_req, chg5, coin_rej,
// vend_ok, busy, fault, credit out. Macro VEND_TIMEOUT_EN adds the watchdog.
module vending_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE_A      = 20,
  parameter int PRICE_B      = 25,
  parameter int CREDIT_MAX   = 35,
  parameter int CW           = 6,
  parameter int DISP_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    coin,
  input  logic [1:0]    sel,
  output logic          motor_req,
  input  logic          motor_done,
  output logic          chg5,
  output logic          coin_rej,
  output logic          vend_ok,
  output logic          busy,
  output logic          fault,
  output logic [CW-1:0] credit
);

  localparam logic [CW-1:0] PA   = CW'(PRICE_A);
  localparam logic [CW-1:0] PB   = CW'(PRICE_B);
  localparam logic [CW:0]   CMAX = (CW+1)'(CREDIT_MAX);
  localparam logic [CW-1:0] C5   = CW'(VAL_5);
  localparam logic [CW-1:0] C10  = CW'(VAL_10);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          motor_req_q, chg5_q, busy_q;
  logic          coin_ok, vend_ok_c;
  logic [CW-1:0] coin_val;
  logic [CW:0]   coin_sum;

`ifdef VEND_TIMEOUT_EN
  logic          tmo_tc;
  logic          fault_q;
  logic          sel_b_q, sel_b_d;

  vend_timer #(
    .TC (DISP_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != S_VEND),
    .tc_o  (tmo_tc)
  );
`endif

  always_comb begin
    coin_val = '0;
    unique case (1'b1)
      (coin == COIN_5):  coin_val = C5;
      (coin == COIN_10): coin_val = C10;
      default:           coin_val = '0;
    endcase
  end

  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    coin_ok   = 1'b0;
    vend_ok_c = 1'b0;
`ifdef VEND_TIMEOUT_EN
    sel_b_d   = sel_b_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // sel has priority; a coin arriving with any sel is bounced
        if (sel == SEL_A && credit_q >= PA) begin
          state_d  = S_VEND;
          credit_d = credit_q - PA;
`ifdef VEND_TIMEOUT_EN
          sel_b_d  = 1'b0;
`endif
        end else if (sel == SEL_B && credit_q >= PB) begin
          state_d  = S_VEND;
          credit_d = credit_q - PB;
`ifdef VEND_TIMEOUT_EN
          sel_b_d  = 1'b1;
`endif
        end else if (sel == SEL_CANCEL && credit_q != '0) begin
          state_d = S_CHANGE;
        end else if (sel == SEL_NONE && coin_val != '0
                     && coin_sum <= CMAX) begin
          coin_ok  = 1'b1;
          credit_d = coin_sum[CW-1:0];
        end
      end
      S_VEND: begin
        if (motor_done) begin
          vend_ok_c = 1'b1;
          state_d   = (credit_q != '0) ? S_CHANGE : S_IDLE;
`ifdef VEND_TIMEOUT_EN
        end else if (tmo_tc) begin
          // restore the price so the owed refund is visible
          state_d  = S_FAULT;
          credit_d = credit_q + (sel_b_q ? PB : PA);
`endif
        end
      end
      S_CHANGE: begin
        if (credit_q <= C5) begin
          credit_d = '0;
          state_d  = S_IDLE;
        end else begin
          credit_d = credit_q - C5;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      motor_req_q <= 1'b0;
      chg5_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      fault_q     <= 1'b0;
      sel_b_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      motor_req_q <= (state_d == S_VEND);
      chg5_q      <= (state_d == S_CHANGE);
      busy_q      <= (state_d != S_IDLE);
`ifdef VEND_TIMEOUT_EN
      fault_q     <= (state_d == S_FAULT);
      sel_b_q     <= sel_b_d;
`endif
    end
  end

`ifdef VEND_TIMEOUT_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign motor_req = motor_req_q;
  assign chg5      = chg5_q;
  assign busy      = busy_q;
  assign credit    = credit_q;
  assign coin_rej  = rst && (coin != COIN_NONE) && !coin_ok;
  assign vend_ok   = rst && vend_ok_c;

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed self-checking bench for vending_ctrl.
// Expected values are hand-computed per scenario.
module tb_vending_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin = 2'b00;
  logic [1:0] sel = 2'b00;
  logic       motor_done = 1'b0;
  logic       motor_req, chg5, coin_rej, vend_ok, busy, fault;
  logic [5:0] credit;

  int n_vec = 0;
  int n_bad = 0;

  vending_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .coin       (coin),
    .sel        (sel),
    .motor_req  (motor_req),
    .motor_done (motor_done),
    .chg5       (chg5),
    .coin_rej   (coin_rej),
    .vend_ok    (vend_ok),
    .busy       (busy),
    .fault      (fault),
    .credit     (credit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] c, input bit exp_rej);
    coin = c;
    #1;
    chk("coin_rej", int'(coin_rej), int'(exp_rej));
    step();
    coin = 2'b00;
  endtask

  task automatic press(input logic [1:0] s);
    sel = s;
    step();
    sel = 2'b00;
  endtask

  task automatic done_pulse(input bit exp_ok);
    motor_done = 1'b1;
    #1;
    chk("vend_ok", int'(vend_ok), int'(exp_ok));
    step();
    motor_done = 1'b0;
  endtask

  // counts chg5 pulses until busy drops, bounded
  task automatic drain(input string tag, input int exp);
    int n = 0;
    int k = 0;
    while (busy && k < 20) begin
      if (chg5) n++;
      step();
      k++;
    end
    chk({tag, "_timeout"}, int'(busy), 0);
    chk({tag, "_pulses"}, n, exp);
    chk({tag, "_credit"}, int'(credit), 0);
  endtask

  initial begin
    rst = 1'b0;
    step();
    step();
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_motor", int'(motor_req), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_chg5", int'(chg5), 0);
    rst = 1'b1;
    step();

    // 1: exact credit, no change
    put_coin(2'b01, 0);
    put_coin(2'b10, 0);
    put_coin(2'b01, 0);
    chk("t1_credit20", int'(credit), 20);
    press(2'b01);
    chk("t1_motor", int'(motor_req), 1);
    chk("t1_credit0", int'(credit), 0);
    step();
    step();
    done_pulse(1);
    chk("t1_busy", int'(busy), 0);
    chk("t1_motor_off", int'(motor_req), 0);
    chk("t1_chg5", int'(chg5), 0);

    // 2: 30 paid for A, two change coins
    put_coin(2'b10, 0);
    put_coin(2'b10, 0);
    put_coin(2'b10, 0);
    press(2'b01);
    chk("t2_credit", int'(credit), 10);
    done_pulse(1);
    chk("t2_chg_a", int'(chg5), 1);
    chk("t2_cr_a", int'(credit), 10);
    step();
    chk("t2_chg_b", int'(chg5), 1);
    chk("t2_cr_b", int'(credit), 5);
    step();
    chk("t2_chg_c", int'(chg5), 0);
    chk("t2_cr_c", int'(credit), 0);
    chk("t2_busy", int'(busy), 0);

    // 3: ceiling and invalid coin
    put_coin(2'b10, 0);
    put_coin(2'b10, 0);
    put_coin(2'b10, 0);
    put_coin(2'b01, 0);
    chk("t3_credit35", int'(credit), 35);
    put_coin(2'b01, 1);
    chk("t3_hold", int'(credit), 35);
    put_coin(2'b11, 1);
    chk("t3_hold2", int'(credit), 35);
    press(2'b11);
    drain("t3", 7);

    // 4: insufficient B, then cancel
    put_coin(2'b10, 0);
    put_coin(2'b01, 0);
    press(2'b10);
    chk("t4_busy", int'(busy), 0);
    chk("t4_credit", int'(credit), 15);
    press(2'b11);
    drain("t4", 3);

    // 5: inputs during VEND
    put_coin(2'b10, 0);
    put_coin(2'b10, 0);
    press(2'b01);
    put_coin(2'b10, 1);
    chk("t5_credit", int'(credit), 0);
    press(2'b11);
    chk("t5_busy", int'(busy), 1);
    chk("t5_motor", int'(motor_req), 1);
    chk("t5_chg5", int'(chg5), 0);
    done_pulse(1);
    chk("t5_idle", int'(busy), 0);
    done_pulse(0);
    chk("t5_idle2", int'(busy), 0);

    // sel and coin together: sel uses pre-coin credit
    put_coin(2'b10, 0);
    put_coin(2'b10, 0);
    sel = 2'b01;
    put_coin(2'b01, 1);
    sel = 2'b00;
    chk("sc_credit", int'(credit), 0);
    chk("sc_motor", int'(motor_req), 1);
    done_pulse(1);
    chk("sc_idle", int'(busy), 0);

    // 6: watchdog
    put_coin(2'b10, 0);
    put_coin(2'b10, 0);
    put_coin(2'b01, 0);
    press(2'b10);
    chk("t6_credit0", int'(credit), 0);
`ifdef VEND_TIMEOUT_EN
    repeat (14) step();
    chk("t6_nofault", int'(fault), 0);
    chk("t6_motor", int'(motor_req), 1);
    step();
    chk("t6_fault", int'(fault), 1);
    chk("t6_credit", int'(credit), 25);
    chk("t6_motor_off", int'(motor_req), 0);
    done_pulse(0);
    chk("t6_stuck", int'(fault), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_rst_fault", int'(fault), 0);
    chk("t6_rst_credit", int'(credit), 0);
    chk("t6_rst_busy", int'(busy), 0);
`else
    repeat (20) step();
    chk("t6_nofault", int'(fault), 0);
    chk("t6_waiting", int'(motor_req), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_rst_motor", int'(motor_req), 0);
    chk("t6_rst_credit", int'(credit), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
